alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage.sv | 136 +++++++++++++
 tb/tb_alu_result_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Multi-cycle ALU result stage: captures an operation on start, waits SETTLE_CYCLES, then registers result and flags.
// Define ALU_FLAGS_EN to register zero/sign/carry; otherwise the flag ports are tied to 0.
module alu_result_stage #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] func,
   input  logic [7:0] b,
   input  logic [7:0] c,
   output logic       busy,
   output logic       done,
   output logic [7:0] result,
   output logic       zero,
   output logic       sign,
   output logic       carry
);

   localparam int unsigned CW = 4;
   localparam int unsigned SW = 2;

   localparam logic [SW-1:0] IDLE   = 2'd0;
   localparam logic [SW-1:0] SETTLE = 2'd1;
   localparam logic [SW-1:0] DONE   = 2'd2;

   logic [SW-1:0] state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          load, complete;
   logic [2:0]    func_q;
   logic [7:0]    b_q, c_q;
   logic [7:0]    alu_res;

   // Next-state and counter control
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      load     = 1'b0;
      complete = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               load     = 1'b1;
               cnt_nx   = CW'(SETTLE_CYCLES - 1);
               state_nx = SETTLE;
            end else begin
               state_nx = IDLE;
            end
         end
         SETTLE: begin
            if (cnt != CW'(0)) begin
               cnt_nx = cnt - CW'(1);
            end else begin
               complete = 1'b1;
               state_nx = DONE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Result datapath on captured operands
   always_comb begin
      alu_res = 8'h00;
      case (func_q)
         3'b000:  alu_res = b_q + c_q;
         3'b001:  alu_res = b_q + 8'd1;
         3'b010:  alu_res = b_q & c_q;
         3'b011:  alu_res = b_q | c_q;
         3'b100:  alu_res = b_q ^ c_q;
         3'b101:  alu_res = ~b_q;
         3'b110:  alu_res = {b_q[6:0], b_q[7]};
         default: alu_res = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= CW'(0);
         func_q <= 3'b000;
         b_q    <= 8'h00;
         c_q    <= 8'h00;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= 8'h00;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         busy  <= (state_nx == SETTLE);
         done  <= (state_nx == DONE);
         if (load) begin
            func_q <= func;
            b_q    <= b;
            c_q    <= c;
         end
         if (complete) begin
            result <= alu_res;
         end
      end
   end

`ifdef ALU_FLAGS_EN
   logic [8:0] sum9;
   logic       alu_carry;

   // Carry-out per function; logical ops never carry
   always_comb begin
      sum9      = {1'b0, b_q} + {1'b0, c_q};
      alu_carry = 1'b0;
      case (func_q)
         3'b000:  alu_carry = sum9[8];
         3'b001:  alu_carry = &b_q;
         3'b110:  alu_carry = b_q[7];
         default: alu_carry = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         zero  <= 1'b0;
         sign  <= 1'b0;
         carry <= 1'b0;
      end else if (complete) begin
         zero  <= (alu_res == 8'h00);
         sign  <= alu_res[7];
         carry <= alu_carry;
      end
   end
`else
   assign zero  = 1'b0;
   assign sign  = 1'b0;
   assign carry = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed vectors, random ops against an arithmetic model,
// ignored mid-operation start, reset abort and back-to-back operation.
module tb_alu_result_stage;

   localparam int unsigned S = 4;
   localparam int MAXWAIT = 40;

   logic       clk = 1'b0;
   logic       reset, start;
   logic [2:0] func;
   logic [7:0] b, c;
   logic       busy, done, zero, sign, carry;
   logic [7:0] result;

   int vectors = 0;
   int miscompares = 0;

   alu_result_stage #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .reset(reset), .start(start), .func(func), .b(b), .c(c),
      .busy(busy), .done(done), .result(result), .zero(zero), .sign(sign), .carry(carry)
   );

   always #5 clk = ~clk;

   // Reference: plain arithmetic from the function table
   task automatic model(input int f, input int bv, input int cv,
                        output logic [7:0] r, output logic z, output logic s, output logic cy);
      int x;
      int k;
      k = 0;
      case (f)
         0: begin x = bv + cv; k = (x > 255) ? 1 : 0; x = x % 256; end
         1: begin x = (bv + 1) % 256; k = (bv == 255) ? 1 : 0; end
         2: x = bv & cv;
         3: x = bv | cv;
         4: x = bv ^ cv;
         5: x = 255 - bv;
         6: begin x = (bv * 2) % 256 + bv / 128; k = (bv >= 128) ? 1 : 0; end
         default: x = 0;
      endcase
      r = 8'(x);
`ifdef ALU_FLAGS_EN
      z  = (x == 0);
      s  = (x >= 128);
      cy = (k != 0);
`else
      z  = 1'b0;
      s  = 1'b0;
      cy = 1'b0;
`endif
   endtask

   // Drive start for exactly one edge; caller is already at a negedge
   task automatic pulse_start(input int f, input int bv, input int cv);
      start = 1'b1;
      func  = 3'(f);
      b     = 8'(bv);
      c     = 8'(cv);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Count negedges after the start edge until done; latency = count-1 edges
   task automatic wait_done(output int lat, output int busy_bad);
      int n;
      n = 0;
      busy_bad = 0;
      lat = -1;
      while (n < MAXWAIT) begin
         @(negedge clk);
         n++;
         if (done) begin
            lat = n - 1;
            break;
         end
         if (busy !== 1'b1) busy_bad++;
      end
   endtask

   task automatic run_op(input int f, input int bv, input int cv, input string tag);
      logic [7:0] er;
      logic ez, es, ec;
      int lat, bb;
      model(f, bv, cv, er, ez, es, ec);
      @(negedge clk);
      pulse_start(f, bv, cv);
      wait_done(lat, bb);
      vectors++;
      if (lat != int'(S) || bb != 0) begin
         miscompares++;
         $display("FAIL %s latency: got %0d (busy drops %0d), expected %0d", tag, lat, bb, S);
      end
      vectors++;
      if (result !== er || zero !== ez || sign !== es || carry !== ec) begin
         miscompares++;
         $display("FAIL %s f=%0d b=%h c=%h: got r=%h z%b s%b c%b, expected r=%h z%b s%b c%b",
                  tag, f, bv, cv, result, zero, sign, carry, er, ez, es, ec);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; func = 3'd0; b = 8'h00; c = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({busy, done, result, zero, sign, carry} !== 13'd0) begin
         miscompares++;
         $display("FAIL reset_state: got busy%b done%b r=%h z%b s%b c%b, expected all 0",
                  busy, done, result, zero, sign, carry);
      end
      // reset has priority over start
      start = 1'b1;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_priority: busy got %b expected 0", busy);
      end
      start = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_directed;
      run_op(0, 8'hF0, 8'h20, "add_carry");
      run_op(1, 8'hFF, 8'h00, "inc_wrap");
      run_op(6, 8'h81, 8'h00, "rol");
      run_op(2, 8'hCA, 8'h5C, "and");
      run_op(3, 8'hCA, 8'h5C, "or");
      run_op(4, 8'hCA, 8'h5C, "xor");
      run_op(5, 8'hCA, 8'h5C, "not");
      run_op(7, 8'hAB, 8'hCD, "clr");
      run_op(0, 8'h00, 8'h00, "add_zero");
   endtask

   task automatic test_hold;
      logic [7:0] r0;
      logic z0, s0, c0;
      r0 = result; z0 = zero; s0 = sign; c0 = carry;
      b = 8'h55; c = 8'h33; func = 3'd4;
      repeat (5) @(negedge clk);
      vectors++;
      if (result !== r0 || zero !== z0 || sign !== s0 || carry !== c0 || done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL hold: got r=%h done%b busy%b, expected r=%h idle", result, done, busy, r0);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), "random");
      end
   endtask

   task automatic test_ignore_start;
      logic [7:0] er;
      logic ez, es, ec;
      int n_done, first_at;
      model(0, 8'h11, 8'h22, er, ez, es, ec);
      @(negedge clk);
      pulse_start(0, 8'h11, 8'h22);
      n_done = 0;
      first_at = -1;
      for (int n = 1; n <= int'(S) + 5; n++) begin
         @(negedge clk);
         if (done) begin
            n_done++;
            if (first_at < 0) first_at = n - 1;
         end
         if (n == 2) pulse_start(3, 8'hF0, 8'h0F);
      end
      vectors++;
      if (n_done != 1 || first_at != int'(S)) begin
         miscompares++;
         $display("FAIL ignore_start: got %0d done pulses first at %0d, expected 1 at %0d", n_done, first_at, S);
      end
      vectors++;
      if (result !== er) begin
         miscompares++;
         $display("FAIL ignore_start_result: got %h expected %h", result, er);
      end
   endtask

   task automatic test_reset_abort;
      int n_done, n_busy;
      run_op(3, 8'h80, 8'h01, "pre_abort");
      @(negedge clk);
      pulse_start(0, 8'h05, 8'h06);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || {zero, sign, carry} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_abort: got busy%b done%b r=%h, expected 0 0 00", busy, done, result);
      end
      n_done = 0; n_busy = 0;
      for (int n = 0; n < int'(S) + 4; n++) begin
         @(negedge clk);
         if (done) n_done++;
         if (busy) n_busy++;
      end
      vectors++;
      if (n_done != 0 || n_busy != 0) begin
         miscompares++;
         $display("FAIL reset_abort_quiet: got %0d done, %0d busy cycles, expected 0 0", n_done, n_busy);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] er;
      logic ez, es, ec;
      int lat, bb;
      run_op(0, 8'h7F, 8'h01, "b2b_first");
      // still at the negedge where done is high: start again from DONE
      model(1, 8'h3C, 8'h00, er, ez, es, ec);
      pulse_start(1, 8'h3C, 8'h00);
      wait_done(lat, bb);
      vectors++;
      if (lat != int'(S) || bb != 0) begin
         miscompares++;
         $display("FAIL back_to_back latency: got %0d (busy drops %0d), expected %0d", lat, bb, S);
      end
      vectors++;
      if (result !== er || zero !== ez || sign !== es || carry !== ec) begin
         miscompares++;
         $display("FAIL back_to_back result: got %h expected %h", result, er);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL done_pulse_width: got done%b busy%b, expected 0 0", done, busy);
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_hold;
      test_random;
      test_ignore_start;
      test_reset_abort;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
